// File: rtl/bk_bist_pkg.sv
// Shared types and helpers for the Brent-Kung adder BIST engine.
// Optional build macro BK_BIST_STOP_ON_FAIL_EN is consumed by bk_adder_bist.
package bk_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bist_state_t;

    localparam int BK_WIDTH = 4;

    function automatic int vec_count(input int w);
        return 1 << (2 * w + 1);
    endfunction

    typedef struct packed {
        logic [2*BK_WIDTH:0] idx;
        logic [BK_WIDTH:0]   exp;
    } bk_rec_t;

endpackage

// File: rtl/bk_bist_pipe.sv
// LATENCY-deep valid-tagged delay line carrying {idx, exp} to the compare point.
// LATENCY=0 is a pure pass-through for combinational adders.
module bk_bist_pipe
    import bk_bist_pkg::*;
#(
    parameter int  LATENCY = 0,
    parameter type rec_t   = bk_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  rec_t in_rec,
    output logic out_valid,
    output rec_t out_rec
);

    generate
        if (LATENCY == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst_n, flush};
            assign out_valid = in_valid;
            assign out_rec   = in_rec;
        end else begin : g_line
            logic [LATENCY-1:0] v_q;
            rec_t               d_q [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= in_valid & ~flush;
                    d_q[0] <= in_rec;
                    for (int i = 1; i < LATENCY; i++) begin
                        v_q[i] <= v_q[i-1] & ~flush;
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign out_valid = v_q[LATENCY-1];
            assign out_rec   = d_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/bk_adder_bist.sv
// Exhaustive stimulus/response BIST for the Brent-Kung adder path.
// Define BK_BIST_STOP_ON_FAIL_EN to end a sweep at the first mismatch.
module bk_adder_bist
    import bk_bist_pkg::*;
#(
    parameter int WIDTH   = BK_WIDTH,
    parameter int LATENCY = 0,
    parameter int ERR_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    output logic               dut_valid,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   fail_vec,
    output logic               fail_valid
);

    localparam int            IW   = 2 * WIDTH + 1;
    localparam int            NVEC = vec_count(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(NVEC - 1);
    localparam int            CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic [IW-1:0]  idx;
        logic [WIDTH:0] exp;
    } rec_t;

    bist_state_t    state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [CW-1:0]  drain_q;
    logic [WIDTH:0] exp_w;
    rec_t           issue_rec, resp_rec;
    logic           resp_valid;
    logic           mismatch;
    logic           stop;
    logic           drain_last;

    assign dut_a   = idx_q[WIDTH-1:0];
    assign dut_b   = idx_q[2*WIDTH-1:WIDTH];
    assign dut_cin = idx_q[2*WIDTH];

    assign exp_w = {1'b0, dut_a} + {1'b0, dut_b}
                 + {{WIDTH{1'b0}}, dut_cin};

    assign issue_rec.idx = idx_q;
    assign issue_rec.exp = exp_w;

    bk_bist_pipe #(
        .LATENCY (LATENCY),
        .rec_t   (rec_t)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (stop),
        .in_valid  (dut_valid),
        .in_rec    (issue_rec),
        .out_valid (resp_valid),
        .out_rec   (resp_rec)
    );

    assign mismatch = resp_valid && busy
                   && ({dut_cout, dut_sum} != resp_rec.exp);

`ifdef BK_BIST_STOP_ON_FAIL_EN
    assign stop = mismatch;
`else
    assign stop = 1'b0;
`endif

    assign drain_last = (drain_q == CW'(LATENCY - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dut_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                dut_valid = 1'b1;
                busy      = 1'b1;
                if (stop) begin
                    state_d = DONE;
                end else if (idx_q == LAST) begin
                    state_d = (LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (stop || drain_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers: cleared on accepted start, updated on compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            drain_q    <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                idx_q      <= '0;
                err_count  <= '0;
                fail_valid <= 1'b0;
                pass       <= 1'b0;
            end
            if (state_q == RUN) begin
                idx_q <= idx_q + 1'b1;
            end
            drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!fail_valid) begin
                    fail_vec   <= resp_rec.idx;
                    fail_valid <= 1'b1;
                end
            end
            if (state_q == DONE) begin
                pass <= (err_count == '0);
            end
        end
    end

endmodule
